// File: rtl/dmem_responder_if.sv
// Load/store bus between the core datapath and dmem_responder.
// Core side drives the request fields; the responder answers.
`timescale 1ns/1ps
interface dmem_responder_if;
  logic        Req;
  logic        Wr;
  logic [63:0] Addr;
  logic [1:0]  tam;
  logic [63:0] Datain;
  logic        Busy;
  logic        Ready;
  logic        Err;
  logic [63:0] Dataout;

  modport master (
    output Req, Wr, Addr, tam, Datain,
    input  Busy, Ready, Err, Dataout
  );

  modport slave (
    input  Req, Wr, Addr, tam, Datain,
    output Busy, Ready, Err, Dataout
  );
endinterface

// File: rtl/dmem_responder.sv
// Doubleword data memory with wait states and RMW sub-word stores.
// Loads are zero-extended; sign handling stays in the core.
`timescale 1ns/1ps
module dmem_responder #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input logic          Clk,
  input logic          Reset,
  dmem_responder_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t      state;
  logic        wrQ;
  logic [63:0] addrQ;
  logic [1:0]  tamQ;
  logic [63:0] dataQ;
  logic [3:0]  cnt;

  logic [63:0] mem [2**ADDR_W];

  logic [ADDR_W-1:0] idx;
  logic [2:0]  off;
  logic [7:0]  szMask;
  logic [7:0]  byteEn;
  logic [63:0] szBits;
  logic [63:0] bitMask;
  logic [63:0] word;
  logic [63:0] loadVal;
  logic [63:0] storeVal;
  logic        misal;
  logic        oor;
  logic        accErr;
  logic        doAccess;

  assign idx  = addrQ[ADDR_W+2:3];
  assign off  = addrQ[2:0];
  assign word = mem[idx];

  always_comb begin
    szMask = 8'h00;
    misal  = 1'b0;
    unique case (1'b1)
      (tamQ == 2'b00): begin
        szMask = 8'hFF;
        misal  = |off;
      end
      (tamQ == 2'b01): begin
        szMask = 8'h0F;
        misal  = |off[1:0];
      end
      (tamQ == 2'b10): begin
        szMask = 8'h03;
        misal  = off[0];
      end
      (tamQ == 2'b11): begin
        szMask = 8'h01;
      end
    endcase
  end

  // any index bit above the array is a range error
  assign oor    = |(addrQ >> (ADDR_W + 3));
  assign accErr = oor | misal;
  assign byteEn = szMask << off;

  always_comb begin
    szBits  = '0;
    bitMask = '0;
    for (int i = 0; i < 8; i++) begin
      szBits[8*i +: 8]  = {8{szMask[i]}};
      bitMask[8*i +: 8] = {8{byteEn[i]}};
    end
  end

  assign loadVal  = (word >> {off, 3'b000}) & szBits;
  assign storeVal = (word & ~bitMask)
                  | ((dataQ << {off, 3'b000}) & bitMask);

  assign doAccess = (state == WAIT) && (cnt == 4'd0);

  // Reset forces IDLE, so a dropped store never reaches the array.
  always_ff @(posedge Clk) begin
    if (doAccess && wrQ && !accErr)
      mem[idx] <= storeVal;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      bus.Busy    <= 1'b0;
      bus.Ready   <= 1'b0;
      bus.Err     <= 1'b0;
      bus.Dataout <= '0;
      wrQ         <= 1'b0;
      addrQ       <= '0;
      tamQ        <= '0;
      dataQ       <= '0;
      cnt         <= '0;
    end else begin
      case (state)
        IDLE, RESP: begin
          bus.Ready <= 1'b0;
          bus.Err   <= 1'b0;
          if (bus.Req) begin
            wrQ      <= bus.Wr;
            addrQ    <= bus.Addr;
            tamQ     <= bus.tam;
            dataQ    <= bus.Datain;
            cnt      <= 4'(LATENCY);
            bus.Busy <= 1'b1;
            state    <= WAIT;
          end else begin
            state <= IDLE;
          end
        end
        WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            bus.Busy  <= 1'b0;
            bus.Ready <= 1'b1;
            bus.Err   <= accErr;
            if (!wrQ && !accErr)
              bus.Dataout <= loadVal;
            state <= RESP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed table, corner sequences,
// and random traffic against a byte-level memory model.
`timescale 1ns/1ps
module tb_dmem_responder;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  dmem_responder_if b ();
  dmem_responder_if b0 ();

  dmem_responder #(.ADDR_W(8), .LATENCY(2)) dut (
    .Clk(Clk), .Reset(Reset), .bus(b.slave)
  );
  dmem_responder #(.ADDR_W(8), .LATENCY(0)) dut0 (
    .Clk(Clk), .Reset(Reset), .bus(b0.slave)
  );

  int total = 0;
  int bad = 0;
  logic [7:0]  mb [2048];
  logic [63:0] expQ;

  typedef struct {
    logic        wr;
    logic [63:0] a;
    logic [1:0]  t;
    logic [63:0] d;
    logic        e;
    logic [63:0] q;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string n, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask

  function automatic int sz(input logic [1:0] t);
    return 8 >> t;
  endfunction

  function automatic logic mErr(input logic [63:0] a,
                                input logic [1:0] t);
    return (a >= 64'd2048) || ((a % 64'(sz(t))) != 64'd0);
  endfunction

  function automatic logic [63:0] mLoad(input logic [63:0] a,
                                        input logic [1:0] t);
    logic [63:0] q;
    q = '0;
    for (int i = 0; i < sz(t); i++)
      q[8*i +: 8] = mb[a[10:0] + 11'(i)];
    return q;
  endfunction

  task automatic mOp(input logic wr, input logic [63:0] a,
                     input logic [1:0] t, input logic [63:0] d,
                     output logic e);
    e = mErr(a, t);
    if (!e) begin
      if (wr) begin
        for (int i = 0; i < sz(t); i++)
          mb[a[10:0] + 11'(i)] = d[8*i +: 8];
      end else begin
        expQ = mLoad(a, t);
      end
    end
  endtask

  task automatic xact(input logic wr, input logic [63:0] a,
                      input logic [1:0] t, input logic [63:0] d,
                      input bit now, input bit hold,
                      output int lat, output logic e,
                      output logic [63:0] q, output logic hsOk);
    if (!now) @(negedge Clk);
    b.Req = 1'b1;
    b.Wr = wr;
    b.Addr = a;
    b.tam = t;
    b.Datain = d;
    @(posedge Clk);
    #1;
    if (!hold) begin
      b.Req = 1'b0;
    end else begin
      b.Datain = ~d;
      b.Addr = a ^ 64'h8;
    end
    lat = 0;
    hsOk = 1'b1;
    while (lat < 40 && !b.Ready) begin
      if (!b.Busy || b.Err) hsOk = 1'b0;
      @(posedge Clk);
      #1;
      lat++;
    end
    if (b.Busy || !b.Ready) hsOk = 1'b0;
    e = b.Err;
    q = b.Dataout;
    b.Req = 1'b0;
  endtask

  task automatic xact0(input logic wr, input logic [63:0] a,
                       input logic [63:0] d, output int lat,
                       output logic [63:0] q);
    @(negedge Clk);
    b0.Req = 1'b1;
    b0.Wr = wr;
    b0.Addr = a;
    b0.tam = 2'b00;
    b0.Datain = d;
    @(posedge Clk);
    #1;
    b0.Req = 1'b0;
    lat = 0;
    while (lat < 40 && !b0.Ready) begin
      @(posedge Clk);
      #1;
      lat++;
    end
    q = b0.Dataout;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: no finish by time limit");
    $fatal(1);
  end

  initial begin
    int lat;
    logic e, me, hs, flag;
    logic [63:0] q, a, d;
    logic [1:0] t;
    logic wr;

    b.Req = 0; b.Wr = 0; b.Addr = 0; b.tam = 0; b.Datain = 0;
    b0.Req = 0; b0.Wr = 0; b0.Addr = 0; b0.tam = 0; b0.Datain = 0;

    repeat (2) @(posedge Clk);
    #1;
    chk("rst_busy", 64'(b.Busy), 64'd0);
    chk("rst_ready", 64'(b.Ready), 64'd0);
    chk("rst_err", 64'(b.Err), 64'd0);
    chk("rst_dout", b.Dataout, 64'd0);
    @(negedge Clk);
    Reset = 1'b0;

    tbl[0]  = '{1'b1, 64'h0,   2'b00, 64'hCAFEF00D12345678, 1'b0, 64'h0};
    tbl[1]  = '{1'b1, 64'h10,  2'b00, 64'h1122334455667788, 1'b0, 64'h0};
    tbl[2]  = '{1'b0, 64'h10,  2'b00, 64'h0, 1'b0, 64'h1122334455667788};
    tbl[3]  = '{1'b1, 64'h13,  2'b11, 64'hFFFFFFFFFFFFFFAA, 1'b0,
                64'h1122334455667788};
    tbl[4]  = '{1'b0, 64'h10,  2'b00, 64'h0, 1'b0, 64'h11223344AA667788};
    tbl[5]  = '{1'b0, 64'h14,  2'b01, 64'h0, 1'b0, 64'h11223344};
    tbl[6]  = '{1'b0, 64'h12,  2'b10, 64'h0, 1'b0, 64'hAA66};
    tbl[7]  = '{1'b0, 64'h11,  2'b00, 64'h0, 1'b1, 64'hAA66};
    tbl[8]  = '{1'b1, 64'h800, 2'b00, 64'h0123456789ABCDEF, 1'b1, 64'hAA66};
    tbl[9]  = '{1'b0, 64'h0,   2'b00, 64'h0, 1'b0, 64'hCAFEF00D12345678};
    tbl[10] = '{1'b0, 64'h15,  2'b11, 64'h0, 1'b0, 64'h33};
    tbl[11] = '{1'b0, 64'h16,  2'b01, 64'h0, 1'b1, 64'h33};
    tbl[12] = '{1'b1, 64'h7F9, 2'b10, 64'h1, 1'b1, 64'h33};

    for (int i = 0; i < 13; i++) begin
      xact(tbl[i].wr, tbl[i].a, tbl[i].t, tbl[i].d, 1'b0, 1'b0,
           lat, e, q, hs);
      chk($sformatf("tbl%0d_err", i), 64'(e), 64'(tbl[i].e));
      chk($sformatf("tbl%0d_dout", i), q, tbl[i].q);
      chk($sformatf("tbl%0d_lat", i), 64'(lat), 64'd3);
      chk($sformatf("tbl%0d_hs", i), 64'(hs), 64'd1);
    end
    expQ = 64'h33;

    for (int i = 0; i < 256; i++) begin
      d = {$urandom, $urandom};
      mOp(1'b1, 64'(i * 8), 2'b00, d, me);
      xact(1'b1, 64'(i * 8), 2'b00, d, 1'b0, 1'b0, lat, e, q, hs);
      chk("init_err", 64'(e), 64'd0);
    end

    for (int i = 0; i < 300; i++) begin
      wr = 1'($urandom_range(0, 1));
      t = 2'($urandom_range(0, 3));
      d = {$urandom, $urandom};
      if ($urandom_range(0, 9) == 0) a = {$urandom, $urandom};
      else a = 64'($urandom_range(0, 2047));
      if ($urandom_range(0, 1) == 1) a = a & ~64'(sz(t) - 1);
      mOp(wr, a, t, d, me);
      xact(wr, a, t, d, 1'($urandom_range(0, 1)), 1'b0, lat, e, q, hs);
      chk($sformatf("rnd%0d_err", i), 64'(e), 64'(me));
      chk($sformatf("rnd%0d_dout", i), q, expQ);
      chk($sformatf("rnd%0d_lat", i), 64'(lat), 64'd3);
      chk($sformatf("rnd%0d_hs", i), 64'(hs), 64'd1);
    end

    mOp(1'b0, 64'h0, 2'b00, 64'h0, me);
    xact(1'b0, 64'h0, 2'b00, 64'h0, 1'b0, 1'b0, lat, e, q, hs);
    chk("b2b_first", q, expQ);
    mOp(1'b0, 64'h8, 2'b00, 64'h0, me);
    xact(1'b0, 64'h8, 2'b00, 64'h0, 1'b1, 1'b0, lat, e, q, hs);
    chk("b2b_dout", q, expQ);
    chk("b2b_lat", 64'(lat), 64'd3);

    d = 64'h5555AAAA5555AAAA;
    mOp(1'b1, 64'h20, 2'b00, d, me);
    xact(1'b1, 64'h20, 2'b00, d, 1'b0, 1'b1, lat, e, q, hs);
    chk("hold_lat", 64'(lat), 64'd3);
    flag = 1'b0;
    repeat (4) begin
      @(posedge Clk);
      #1;
      if (b.Ready || b.Busy) flag = 1'b1;
    end
    chk("hold_single", 64'(flag), 64'd0);
    mOp(1'b0, 64'h20, 2'b00, 64'h0, me);
    xact(1'b0, 64'h20, 2'b00, 64'h0, 1'b0, 1'b0, lat, e, q, hs);
    chk("hold_data", q, expQ);
    mOp(1'b0, 64'h28, 2'b00, 64'h0, me);
    xact(1'b0, 64'h28, 2'b00, 64'h0, 1'b0, 1'b0, lat, e, q, hs);
    chk("hold_neighbor", q, expQ);

    d = 64'h0BADBEEF00000001;
    mOp(1'b1, 64'h18, 2'b00, d, me);
    xact(1'b1, 64'h18, 2'b00, d, 1'b0, 1'b0, lat, e, q, hs);
    mOp(1'b0, 64'h18, 2'b00, 64'h0, me);
    xact(1'b0, 64'h18, 2'b00, 64'h0, 1'b0, 1'b0, lat, e, q, hs);
    chk("pre_rst_dout", q, 64'h0BADBEEF00000001);
    @(negedge Clk);
    b.Req = 1'b1; b.Wr = 1'b1; b.Addr = 64'h18;
    b.tam = 2'b00; b.Datain = 64'hDEAD;
    @(posedge Clk);
    #1;
    b.Req = 1'b0;
    chk("pre_rst_busy", 64'(b.Busy), 64'd1);
    @(negedge Clk);
    Reset = 1'b1;
    #1;
    chk("arst_busy", 64'(b.Busy), 64'd0);
    chk("arst_ready", 64'(b.Ready), 64'd0);
    chk("arst_err", 64'(b.Err), 64'd0);
    chk("arst_dout", b.Dataout, 64'd0);
    @(negedge Clk);
    Reset = 1'b0;
    expQ = 64'h0;
    flag = 1'b0;
    repeat (6) begin
      @(posedge Clk);
      #1;
      if (b.Ready) flag = 1'b1;
    end
    chk("drop_no_ready", 64'(flag), 64'd0);
    mOp(1'b0, 64'h18, 2'b00, 64'h0, me);
    xact(1'b0, 64'h18, 2'b00, 64'h0, 1'b0, 1'b0, lat, e, q, hs);
    chk("drop_old_data", q, 64'h0BADBEEF00000001);

    xact0(1'b1, 64'h40, 64'h0102030405060708, lat, q);
    chk("lat0_store_lat", 64'(lat), 64'd1);
    xact0(1'b0, 64'h40, 64'h0, lat, q);
    chk("lat0_load_lat", 64'(lat), 64'd1);
    chk("lat0_load_dout", q, 64'h0102030405060708);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
